usb_cmd_parser: RTL and testbench
=================================

Name: usb_cmd_parser

Overview:
- Consumes the host byte stream delivered by the USB serial endpoint (rx valid/ready) and decodes framed commands.
- Performs byte-wide writes and reads on an on-chip memory port: weights, activations and control registers of the NN core.
- Returns ACK/NAK and read data to the host over the endpoint's tx valid/ready byte stream.
- Sits between the USB serial core and the NN core's memory map.

Parameters:
- ADDR_WIDTH, 16: memory address width; addresses wrap modulo 2^ADDR_WIDTH.
- TIMEOUT_CYCLES, 480000: maximum idle cycles between bytes inside a frame before abort (10 ms at 48 MHz).
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  byte from USB endpoint
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  parser accepts byte this cycle
- tx_data  out  8  byte to USB endpoint
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  endpoint accepts byte
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  8  write data
- mem_we  out  1  write strobe, one cycle per byte
- mem_re  out  1  read strobe, one cycle per byte
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_re
- busy  out  1  high whenever state != IDLE
- frame_err  out  1  one-cycle pulse on checksum error, bad opcode or timeout

Behaviour:
- Reset: async; all outputs 0, state IDLE, checksum/counters cleared. Reset mid-frame discards the frame with no response; a byte pending on tx is dropped.
- Frame format: SYNC, OPC, ADDR_H, ADDR_L, LEN, payload[LEN], CHK.
  - CHK is the XOR of OPC through the last payload byte.
  - Payload is present only for WRITE.
- Opcodes:
  - 8'h01 WRITE
  - 8'h02 READ
  - 8'h03 PING
  - any other value is BAD
- Response bytes: ACK = 8'h06, NAK = 8'h15.
- rx handshake:
  - A byte is accepted when rx_valid && rx_ready.
  - rx_ready = 1 in IDLE, OPC, ADDR_H, ADDR_L, LEN, PAYLOAD, CHK; 0 in every other state.
- tx handshake:
  - tx_valid stays high with tx_data stable until tx_ready.
  - The byte completes on tx_valid && tx_ready.
- State machine:
  - IDLE: discard bytes that are not SYNC_BYTE; SYNC_BYTE -> OPC.
  - OPC -> ADDR_H -> ADDR_L -> LEN, one accepted byte per transition.
  - LEN: WRITE with LEN != 0 -> PAYLOAD; all other cases -> CHK.
  - PAYLOAD: each accepted byte drives mem_we=1, mem_addr=cur_addr and mem_wdata=byte in the next cycle, then cur_addr increments with wrap. After LEN bytes -> CHK.
  - Writes stream before verification and are not rolled back on NAK.
  - CHK: mismatch or BAD opcode -> pulse frame_err, RESP with NAK. Otherwise RESP with ACK.
  - RESP: on tx completion: NAK/WRITE/PING -> IDLE; READ with LEN = 0 -> IDLE; READ with LEN != 0 -> RD_REQ.
  - RD_REQ: mem_re=1 for one cycle -> RD_WAIT.
  - RD_WAIT: latch mem_rdata into tx_data, tx_valid=1 -> RD_SEND.
  - RD_SEND: on tx completion, increment address and decrement count; count 0 -> IDLE, else -> RD_REQ.
  - Minimum read-byte period is 3 cycles.
- Timeout:
  - Counter resets on every accepted byte and increments while in OPC..CHK.
  - Reaching TIMEOUT_CYCLES -> frame_err pulse, return to IDLE, no response.
  - The counter is not active in IDLE or the tx states.
- Simultaneous events: a byte accepted in the same cycle the counter would reach TIMEOUT_CYCLES is accepted, and the counter clears.
- LEN is 8-bit; 0 means zero payload / zero read bytes. Maximum transfer is 255 bytes.
- Address wrap: 16'hFFFF + 1 -> 16'h0000.

Decomposition:
- nnoc_cmd_pkg holds the shared definitions:
  - opcode enum (OP_WRITE, OP_READ, OP_PING)
  - ACK_BYTE, NAK_BYTE
  - state enum
  - default SYNC_BYTE
- One sub-module, nnoc_byte_timer: timeout counter with clear/enable inputs and an expired output.
- Everything else lives in the FSM module.

Test Plan:
- WRITE A5 01 12 34 03 AA BB CC CHK=(01^12^34^03^AA^BB^CC) -> mem_we pulses at 1234/AA, 1235/BB, 1236/CC; tx emits 06; busy returns to 0.
- Preload 0x0100 = 11, 0x0101 = 22; READ A5 02 01 00 02 CHK -> tx emits 06, 11, 22 in order. Also stall tx_ready low for 5 cycles mid-read -> tx_data held stable, no extra mem_re.
- WRITE with corrupted CHK -> writes occur, frame_err pulses once, tx emits 15. Opcode 7F with valid XOR -> tx emits 15, no mem_we.
- Leading garbage 00 FF 13 then a valid PING -> garbage ignored, single 06 response.
- Send A5 01 then stall for TIMEOUT_CYCLES -> frame_err pulse, no tx. A following valid PING -> 06.
- WRITE to FFFF with LEN=2 -> writes at FFFF and 0000. Assert rst_n low mid-PAYLOAD -> outputs 0 immediately, next frame parses normally.

Source files
------------

// File: rtl/nnoc_cmd_pkg.sv
// Shared definitions for the USB command parser: opcodes, response bytes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package nnoc_cmd_pkg;

    typedef enum logic [7:0] {
        OP_WRITE = 8'h01,
        OP_READ  = 8'h02,
        OP_PING  = 8'h03
    } opcode_t;

    localparam logic [7:0] ACK_BYTE      = 8'h06;
    localparam logic [7:0] NAK_BYTE      = 8'h15;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OPC,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_RESP,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_SEND
    } state_t;

    // True for the three opcodes the parser executes; everything else is NAKed.
    function automatic logic opc_known(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ) || (b == OP_PING);
    endfunction

endpackage

// File: rtl/nnoc_byte_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear, flags LIMIT idle cycles.
// Latency: expired is combinational from the count; count clears one cycle after clr/!en.
// Backpressure: none; clr wins over expiry so a byte arriving on the deadline is kept.
// Ports: clk, rst_n, clr (byte accepted), en (inside a frame), expired (abort request).
module nnoc_byte_timer #(
    parameter int unsigned LIMIT = 480000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    // cnt holds the number of idle cycles already elapsed; this cycle is the LIMIT-th.
    assign expired = en && !clr && (cnt == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/usb_cmd_parser.sv
// Framed command parser: SYNC OPC ADDR_H ADDR_L LEN payload CHK -> byte memory writes/reads, ACK/NAK reply.
// Latency: write strobe one cycle after each payload byte; response the cycle after CHK; read bytes every >=3 cycles.
// Backpressure: rx_ready drops in response/read states; tx_valid/tx_data hold until tx_ready.
// Ports: rx_* byte stream in, tx_* byte stream out, mem_* byte memory port, busy, frame_err pulse.
module usb_cmd_parser
    import nnoc_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 480000,
    parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic                  frame_err
);

    state_t                  state;
    logic                    rdy_en;    // keeps rx_ready low while reset is asserted
    logic [7:0]              opc;
    logic [7:0]              chk;
    logic [7:0]              addr_h;
    logic [7:0]              cnt;       // payload bytes left (WRITE) or read bytes left (READ)
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    nak;
    logic                    rx_fire;
    logic                    tx_fire;
    logic                    in_frame;
    logic                    timed_out;

    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    assign in_frame = state inside {ST_OPC, ST_ADDR_H, ST_ADDR_L, ST_LEN, ST_PAYLOAD, ST_CHK};
    assign rx_ready = rdy_en && (in_frame || (state == ST_IDLE));
    assign busy     = (state != ST_IDLE);

    nnoc_byte_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (rx_fire),
        .en      (in_frame),
        .expired (timed_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rdy_en    <= 1'b0;
            opc       <= '0;
            chk       <= '0;
            addr_h    <= '0;
            cnt       <= '0;
            cur_addr  <= '0;
            nak       <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rdy_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            frame_err <= 1'b0;

            if (timed_out) begin
                // Silent abort: no reply, partial writes already issued stay.
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_fire && (rx_data == SYNC_BYTE)) state <= ST_OPC;
                    end
                    ST_OPC: begin
                        if (rx_fire) begin
                            opc   <= rx_data;
                            chk   <= rx_data;
                            state <= ST_ADDR_H;
                        end
                    end
                    ST_ADDR_H: begin
                        if (rx_fire) begin
                            addr_h <= rx_data;
                            chk    <= chk ^ rx_data;
                            state  <= ST_ADDR_L;
                        end
                    end
                    ST_ADDR_L: begin
                        if (rx_fire) begin
                            cur_addr <= ADDR_WIDTH'({addr_h, rx_data});
                            chk      <= chk ^ rx_data;
                            state    <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_fire) begin
                            cnt   <= rx_data;
                            chk   <= chk ^ rx_data;
                            state <= ((opc == OP_WRITE) && (rx_data != 8'd0)) ? ST_PAYLOAD : ST_CHK;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_fire) begin
                            // Writes go out before the checksum is known.
                            mem_we    <= 1'b1;
                            mem_addr  <= cur_addr;
                            mem_wdata <= rx_data;
                            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                            cnt       <= cnt - 8'd1;
                            chk       <= chk ^ rx_data;
                            if (cnt == 8'd1) state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (rx_fire) begin
                            if (!opc_known(opc) || (chk != rx_data)) begin
                                frame_err <= 1'b1;
                                tx_data   <= NAK_BYTE;
                                nak       <= 1'b1;
                            end else begin
                                tx_data   <= ACK_BYTE;
                                nak       <= 1'b0;
                            end
                            tx_valid <= 1'b1;
                            state    <= ST_RESP;
                        end
                    end
                    ST_RESP: begin
                        if (tx_fire) begin
                            tx_valid <= 1'b0;
                            if (!nak && (opc == OP_READ) && (cnt != 8'd0)) begin
                                // mem_re is registered, so it is high during RD_REQ.
                                mem_re   <= 1'b1;
                                mem_addr <= cur_addr;
                                state    <= ST_RD_REQ;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_RD_REQ: begin
                        state <= ST_RD_WAIT;
                    end
                    ST_RD_WAIT: begin
                        tx_data  <= mem_rdata;
                        tx_valid <= 1'b1;
                        state    <= ST_RD_SEND;
                    end
                    ST_RD_SEND: begin
                        if (tx_fire) begin
                            tx_valid <= 1'b0;
                            cnt      <= cnt - 8'd1;
                            cur_addr <= cur_addr + ADDR_WIDTH'(1);
                            if (cnt == 8'd1) begin
                                state <= ST_IDLE;
                            end else begin
                                mem_re   <= 1'b1;
                                mem_addr <= cur_addr + ADDR_WIDTH'(1);
                                state    <= ST_RD_REQ;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Bench for usb_cmd_parser: frame-level reference model, event scoreboards, byte memory emulation.
// Latency: n/a.
// Backpressure: tx_ready randomised, with one directed 5-cycle stall during a read.
module tb_usb_cmd_parser;

    localparam int T = 40;  // shortened inter-byte timeout

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;
    logic        frame_err;

    always #5 clk = ~clk;

    usb_cmd_parser #(
        .ADDR_WIDTH     (16),
        .TIMEOUT_CYCLES (T),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  model_mem [0:65535];   // what memory must hold per the frame rules
    logic [7:0]  emu_mem   [0:65535];   // what the DUT actually wrote (feeds mem_rdata)
    logic [23:0] exp_wr [$];
    logic [7:0]  exp_tx [$];
    logic [7:0]  tx_log [$];
    logic [7:0]  garb [$];
    logic [7:0]  pl [0:255];
    int          err_cnt = 0, exp_err = 0, re_cnt = 0, exp_re = 0;
    int          tx_idx = 0, stall_cnt = 0;
    bit          stall_req = 0;
    int          max_gap = 0, force_idx = -1, force_gap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    // Per-cycle observer: memory emulation, tx_ready driver, scoreboard pops.
    initial begin : observer
        bit          prev_stall;
        logic [7:0]  prev_data;
        bit          rd_pending;
        logic [15:0] rd_addr;
        prev_stall = 0; prev_data = 0; rd_pending = 0; rd_addr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_ready = 1'b0; prev_stall = 0; rd_pending = 0; stall_cnt = 0;
            end else begin
                // Read data is valid only in the cycle after mem_re; garbage otherwise.
                mem_rdata  = rd_pending ? emu_mem[rd_addr] : 8'($urandom);
                rd_pending = mem_re;
                rd_addr    = mem_addr;
                if (mem_re) re_cnt++;
                if (frame_err) err_cnt++;
                if (mem_we) begin
                    emu_mem[mem_addr] = mem_wdata;
                    if (exp_wr.size() == 0) fail("mem_write_extra", {mem_addr, mem_wdata});
                    else check("mem_write", {8'h00, mem_addr, mem_wdata}, {8'h00, exp_wr.pop_front()});
                end
                if (prev_stall) check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
                if (stall_cnt > 0) begin
                    tx_ready = 1'b0; stall_cnt--;
                end else if (stall_req && tx_valid && tx_idx == 1) begin
                    tx_ready = 1'b0; stall_cnt = 4; stall_req = 0;
                end else begin
                    tx_ready = ($urandom_range(0, 3) != 0);
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                if (tx_valid && tx_ready) begin
                    tx_log.push_back(tx_data);
                    tx_idx++;
                    if (exp_tx.size() == 0) fail("tx_extra", tx_data);
                    else check("tx_byte", tx_data, exp_tx.pop_front());
                end
            end
        end
    end

    // Tasks start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data = b; rx_valid = 1'b1; n = 0;
        forever begin
            acc = rx_ready;
            @(negedge clk);
            if (acc) break;
            n++;
            if (n > 2000) begin fail("rx_accept_timeout", b); break; end
        end
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] frame_chk(input logic [7:0] opc, input logic [15:0] addr, input logic [7:0] len);
        logic [7:0] c;
        c = opc ^ addr[15:8] ^ addr[7:0] ^ len;
        if (opc == 8'h01) for (int i = 0; i < int'(len); i++) c ^= pl[i];
        return c;
    endfunction

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || busy || tx_valid) && n < 5000) begin
            @(negedge clk); n++;
        end
        if (n >= 5000) fail("quiet_timeout", {busy, tx_valid});
        repeat (3) @(negedge clk);
        check("wr_left", exp_wr.size(), 0);
        check("tx_left", exp_tx.size(), 0);
        check("err_count", err_cnt, exp_err);
        check("re_count", re_cnt, exp_re);
        check("busy_idle", busy, 0);
    endtask

    // One frame: build expectations from the frame rules, then drive it.
    task automatic run_frame(input logic [7:0] opc, input logic [15:0] addr, input logic [7:0] len, input bit corrupt);
        logic [7:0] fb [$];
        logic [7:0] c;
        bit wr, bad, tmo;
        wr  = (opc == 8'h01);
        tmo = (force_idx >= 1) && (force_gap >= T);
        fb  = {};
        fb.push_back(8'hA5); fb.push_back(opc); fb.push_back(addr[15:8]); fb.push_back(addr[7:0]); fb.push_back(len);
        if (wr) for (int i = 0; i < int'(len); i++) fb.push_back(pl[i]);
        c = frame_chk(opc, addr, len);
        if (corrupt) c ^= 8'($urandom_range(1, 255));
        fb.push_back(c);
        if (wr) for (int i = 0; i < int'(len); i++) begin
            if (!tmo || (5 + i) < force_idx) begin
                exp_wr.push_back({16'(addr + 16'(i)), pl[i]});
                model_mem[16'(addr + 16'(i))] = pl[i];
            end
        end
        if (tmo) begin
            exp_err++;
        end else begin
            bad = corrupt || !(opc inside {8'h01, 8'h02, 8'h03});
            if (bad) begin
                exp_tx.push_back(8'h15); exp_err++;
            end else begin
                exp_tx.push_back(8'h06);
                if (opc == 8'h02) for (int i = 0; i < int'(len); i++) begin
                    exp_tx.push_back(model_mem[16'(addr + 16'(i))]);
                    exp_re++;
                end
            end
        end
        tx_log = {}; tx_idx = 0;
        foreach (garb[i]) send_byte(garb[i], $urandom_range(0, max_gap));
        for (int k = 0; k < fb.size(); k++) begin
            send_byte(fb[k], (k == force_idx) ? force_gap : $urandom_range(0, max_gap));
            if (k == 0) check("busy_in_frame", busy, 1);
        end
        wait_quiet();
        force_idx = -1; garb = {};
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {rx_ready, tx_valid, mem_we, mem_re, busy, frame_err, tx_data, mem_wdata, mem_addr}, 0);
    endtask

    initial begin : main
        logic [7:0]  opc;
        logic [15:0] addr;
        int          r;
        for (int i = 0; i < 65536; i++) begin model_mem[i] = 8'h00; emu_mem[i] = 8'h00; end

        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        check("rx_ready_after_reset", rx_ready, 1);

        // WRITE 3 bytes at 1234
        pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
        check("chk_model_literal", frame_chk(8'h01, 16'h1234, 8'd3), 8'hF9);
        run_frame(8'h01, 16'h1234, 8'd3, 0);
        check("t1_mem1234", emu_mem[16'h1234], 8'hAA);
        check("t1_mem1235", emu_mem[16'h1235], 8'hBB);
        check("t1_mem1236", emu_mem[16'h1236], 8'hCC);
        check("t1_tx_n", tx_log.size(), 1);
        check("t1_tx0", tx_log[0], 8'h06);

        // READ 2 bytes with a tx stall on the second returned byte
        model_mem[16'h0100] = 8'h11; emu_mem[16'h0100] = 8'h11;
        model_mem[16'h0101] = 8'h22; emu_mem[16'h0101] = 8'h22;
        stall_req = 1;
        run_frame(8'h02, 16'h0100, 8'd2, 0);
        check("t2_tx_n", tx_log.size(), 3);
        check("t2_tx", {tx_log[0], tx_log[1], tx_log[2]}, 24'h061122);

        // Corrupted checksum still writes; bad opcode is NAKed with no writes
        pl[0] = 8'h31; pl[1] = 8'h32;
        run_frame(8'h01, 16'h2000, 8'd2, 1);
        check("t3_nak", tx_log[0], 8'h15);
        check("t3_mem2001", emu_mem[16'h2001], 8'h32);
        run_frame(8'h7F, 16'h3000, 8'd3, 0);
        check("t3_badop_nak", tx_log[0], 8'h15);

        // Garbage before a PING
        garb = {8'h00, 8'hFF, 8'h13};
        run_frame(8'h03, 16'h0000, 8'd0, 0);
        check("t4_tx_n", tx_log.size(), 1);
        check("t4_ack", tx_log[0], 8'h06);

        // Timeout after SYNC OPC
        tx_log = {};
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        repeat (T + 5) @(negedge clk);
        exp_err++;
        wait_quiet();
        check("t5_no_tx", tx_log.size(), 0);
        run_frame(8'h03, 16'h0000, 8'd0, 0);
        check("t5_ping_ack", tx_log[0], 8'h06);

        // Gap of T-1 idle cycles survives; gap of T aborts
        force_idx = 5; force_gap = T - 1;
        run_frame(8'h03, 16'h0000, 8'd0, 0);
        check("t5_gap_edge_ack", tx_log.size(), 1);
        force_idx = 5; force_gap = T;
        run_frame(8'h03, 16'h0000, 8'd0, 0);
        check("t5_gap_timeout_no_tx", tx_log.size(), 0);

        // Address wrap
        pl[0] = 8'h5A; pl[1] = 8'hC3;
        run_frame(8'h01, 16'hFFFF, 8'd2, 0);
        check("t6_memffff", emu_mem[16'hFFFF], 8'h5A);
        check("t6_mem0000", emu_mem[16'h0000], 8'hC3);

        // Reset in the middle of a payload
        pl[0] = 8'h77; pl[1] = 8'h88;
        exp_wr.push_back({16'h4000, 8'h77}); model_mem[16'h4000] = 8'h77;
        exp_wr.push_back({16'h4001, 8'h88}); model_mem[16'h4001] = 8'h88;
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h40, 0);
        send_byte(8'h00, 0); send_byte(8'h04, 0);
        send_byte(8'h77, 0); send_byte(8'h88, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("mid_reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_reset_writes", exp_wr.size(), 0);
        run_frame(8'h02, 16'h4000, 8'd4, 0);
        check("t6_read_after_reset", {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]}, 40'h0677880000);

        // Randomised frames
        for (int f = 0; f < 40; f++) begin
            r       = $urandom_range(0, 9);
            max_gap = $urandom_range(0, 3);
            addr    = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                  : 16'(16'h0100 + $urandom_range(0, 31));
            for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) garb.push_back(8'($urandom_range(0, 8'hA4)));
            if ($urandom_range(0, 7) == 0) begin
                force_idx = $urandom_range(1, 5); force_gap = T - 1;
            end
            case (r)
                0, 1, 2, 3: opc = 8'h01;
                4, 5, 6:    opc = 8'h02;
                7:          opc = 8'h03;
                8:          opc = 8'($urandom_range(4, 255));
                default:    opc = 8'($urandom_range(1, 3));
            endcase
            run_frame(opc, addr, 8'($urandom_range(0, 6)), r == 9);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
